// File: rtl/des_region_scheduler_if.sv
// des_region_scheduler_if: CPU job controls and des_block array wiring for the region scheduler.
//   master: drives start/abort/region range and block done/counter, observes scheduler outputs.
//   slave : the scheduler side.
interface des_region_scheduler_if #(
    parameter int NUM_BLOCKS = 4,
    parameter int REGION_W   = 16,
    parameter int CNT_W      = 48,
    parameter int ACC_W      = 64
);
    logic                           start;
    logic                           abort;
    logic [REGION_W-1:0]            region_first;
    logic [REGION_W-1:0]            region_last;
    logic [NUM_BLOCKS-1:0]          blk_done;
    logic [NUM_BLOCKS*CNT_W-1:0]    blk_counter;
    logic [NUM_BLOCKS-1:0]          blk_start;
    logic [NUM_BLOCKS-1:0]          blk_restart;
    logic [NUM_BLOCKS*REGION_W-1:0] blk_region;
    logic [ACC_W-1:0]               total_count;
    logic [REGION_W:0]              regions_done;
    logic                           busy;
    logic                           done;
    modport master (
        output start, abort, region_first, region_last, blk_done, blk_counter,
        input  blk_start, blk_restart, blk_region, total_count, regions_done, busy, done
    );
    modport slave (
        input  start, abort, region_first, region_last, blk_done, blk_counter,
        output blk_start, blk_restart, blk_region, total_count, regions_done, busy, done
    );
endinterface

// File: rtl/des_region_scheduler.sv
// des_region_scheduler: deals regions [region_first..region_last] out to NUM_BLOCKS des_blocks,
//   collects their counters into a 64-bit total and restarts each block after collection.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of des_region_scheduler_if (job controls, block handshakes, results)
module des_region_scheduler #(
    parameter int NUM_BLOCKS = 4,
    parameter int REGION_W   = 16,
    parameter int CNT_W      = 48,
    parameter int ACC_W      = 64
) (
    input logic                 clk,
    input logic                 rst,
    des_region_scheduler_if.slave bus
);
    localparam int RR_W = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                         state_q, state_d;
    logic [NUM_BLOCKS-1:0]          active_q, active_d, start_q, start_d, restart_q, restart_d;
    logic [RR_W-1:0]                rr_q, rr_d;
    logic [REGION_W:0]              next_q, next_d, last_q, last_d, rdone_q, rdone_d;
    logic [ACC_W-1:0]               total_q, total_d;
    logic [NUM_BLOCKS*REGION_W-1:0] region_q, region_d;
    logic                           col_hit, iss_hit;
    logic [RR_W-1:0]                col_idx, iss_idx, j;

    function automatic logic [RR_W-1:0] wrap_inc(input logic [RR_W-1:0] v);
        return (v == RR_W'(NUM_BLOCKS - 1)) ? '0 : v + 1'b1;
    endfunction

    // Round-robin scan from rr: first ACTIVE block reporting done, and first FREE block.
    always_comb begin
        col_hit = 1'b0;
        iss_hit = 1'b0;
        col_idx = '0;
        iss_idx = '0;
        j       = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            j = RR_W'((int'(rr_q) + k) % NUM_BLOCKS);
            if (!col_hit && active_q[j] && bus.blk_done[j]) begin
                col_hit = 1'b1;
                col_idx = j;
            end
            if (!iss_hit && !active_q[j]) begin
                iss_hit = 1'b1;
                iss_idx = j;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        start_d   = '0;
        restart_d = '0;
        rr_d      = rr_q;
        next_d    = next_q;
        last_d    = last_q;
        total_d   = total_q;
        rdone_d   = rdone_q;
        region_d  = region_q;
        if (bus.abort) begin
            restart_d = '1;
            active_d  = '0;
            state_d   = IDLE;
        end else if (state_q != RUN) begin
            if (bus.start) begin
                next_d  = {1'b0, bus.region_first};
                last_d  = {1'b0, bus.region_last};
                total_d = '0;
                rdone_d = '0;
                // An empty range finishes immediately without touching any block.
                state_d = (bus.region_first > bus.region_last) ? DONE : RUN;
            end
        end else if (col_hit) begin
            total_d           = total_q + ACC_W'(bus.blk_counter[col_idx*CNT_W +: CNT_W]);
            rdone_d           = rdone_q + 1'b1;
            restart_d[col_idx] = 1'b1;
            active_d[col_idx]  = 1'b0;
            rr_d              = wrap_inc(col_idx);
        end else if (iss_hit && next_q <= last_q) begin
            region_d[iss_idx*REGION_W +: REGION_W] = next_q[REGION_W-1:0];
            start_d[iss_idx]  = 1'b1;
            active_d[iss_idx] = 1'b1;
            next_d            = next_q + 1'b1;
            rr_d              = wrap_inc(iss_idx);
        end else if (next_q > last_q && active_q == '0) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            active_q  <= '0;
            start_q   <= '0;
            restart_q <= '0;
            rr_q      <= '0;
            next_q    <= '0;
            last_q    <= '0;
            total_q   <= '0;
            rdone_q   <= '0;
            region_q  <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            start_q   <= start_d;
            restart_q <= restart_d;
            rr_q      <= rr_d;
            next_q    <= next_d;
            last_q    <= last_d;
            total_q   <= total_d;
            rdone_q   <= rdone_d;
            region_q  <= region_d;
        end
    end

    assign bus.blk_start    = start_q;
    assign bus.blk_restart  = restart_q;
    assign bus.blk_region   = region_q;
    assign bus.total_count  = total_q;
    assign bus.regions_done = rdone_q;
    assign bus.busy         = (state_q == RUN);
    assign bus.done         = (state_q == DONE);
endmodule

// File: tb/tb_des_region_scheduler.sv
// tb_des_region_scheduler: scoreboard bench with behavioural des_block models.
module tb_des_region_scheduler;
    localparam int N = 4, RW = 16, CW = 48, AW = 64, LAT = 40;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    des_region_scheduler_if #(.NUM_BLOCKS(N), .REGION_W(RW), .CNT_W(CW), .ACC_W(AW)) bus ();
    des_region_scheduler #(.NUM_BLOCKS(N), .REGION_W(RW), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_total = 0, n_bad = 0, cyc = 0;
    logic [RW-1:0] exp_region[$];
    logic [AW-1:0] exp_tot[$];
    int exp_cnt[$];
    int st_idx[$], st_cyc[$], rs_idx[$], rs_cyc[$];
    bit hold_en = 0, stray_en = 0;
    bit bact[N] = '{default: 0};
    bit done_r[N] = '{default: 0};
    int tmr[N] = '{default: 0};
    logic [RW-1:0] breg[N] = '{default: '0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Block models: done LAT cycles after start with counter 2*region+5; free blocks may drive stray done.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                bact[i]   = 0;
                done_r[i] = 0;
            end else begin
                if (bus.blk_restart[i]) begin
                    bact[i]   = 0;
                    done_r[i] = 0;
                    rs_idx.push_back(i);
                    rs_cyc.push_back(cyc);
                end
                if (bus.blk_start[i]) begin
                    check("restart_gap", 64'(bus.blk_restart[i]), 0);
                    bact[i]   = 1;
                    done_r[i] = 0;
                    tmr[i]    = LAT;
                    breg[i]   = bus.blk_region[i*RW +: RW];
                    st_idx.push_back(i);
                    st_cyc.push_back(cyc);
                    check("region", 64'(breg[i]), exp_region.size() != 0 ? 64'(exp_region.pop_front()) : 'x);
                end else if (bact[i] && !done_r[i]) begin
                    if (tmr[i] > 0) tmr[i]--;
                    if (tmr[i] == 0 && !hold_en) done_r[i] = 1;
                end
            end
            bus.blk_done[i] = bact[i] ? done_r[i] : stray_en;
            bus.blk_counter[i*CW +: CW] = bact[i] ? 48'(2 * int'(breg[i]) + 5) : 48'd1000;
        end
    end

    task automatic begin_job(input int first, input int last);
        longint s = 0;
        for (int r = first; r <= last; r++) begin
            exp_region.push_back(RW'(r));
            s += 2 * r + 5;
        end
        exp_tot.push_back(AW'(s));
        exp_cnt.push_back(last >= first ? last - first + 1 : 0);
        bus.region_first = RW'(first);
        bus.region_last  = RW'(last);
        bus.start        = 1;
        @(negedge clk);
        bus.start = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(bus.done), 1);
        check({tag, "_busy"}, 64'(bus.busy), 0);
        check({tag, "_total"}, bus.total_count, exp_tot.pop_front());
        check({tag, "_rdone"}, 64'(bus.regions_done), 64'(exp_cnt.pop_front()));
        check({tag, "_leftover"}, 64'(exp_region.size()), 0);
    endtask

    initial begin
        int t0, n, mark;
        bit ok;
        bus.start = 0;
        bus.abort = 0;
        bus.region_first = '0;
        bus.region_last = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_total", bus.total_count, 0);
        check("rst_rdone", 64'(bus.regions_done), 0);
        check("rst_start", 64'(bus.blk_start), 0);
        check("rst_restart", 64'(bus.blk_restart), 0);
        check("rst_region", bus.blk_region, 0);
        rst = 0;
        @(negedge clk);

        // T1: three regions on blocks 0,1,2 in consecutive cycles
        t0 = cyc;
        begin_job(0, 2);
        wait_done("t1");
        check("t1_nstart", 64'(st_idx.size()), 3);
        for (int k = 0; k < 3; k++) check("t1_idx", 64'(k < st_idx.size() ? st_idx[k] : -1), 64'(k));
        check("t1_lat", 64'(st_cyc.size() > 0 && st_cyc[0] - t0 >= 2 && st_cyc[0] - t0 <= 3), 1);
        check("t1_consec", 64'(st_cyc.size() >= 3 ? st_cyc[2] - st_cyc[0] : -1), 2);

        // T2: empty range
        n = st_idx.size();
        begin_job(5, 4);
        check("t2_done_next", 64'(bus.done), 1);
        wait_done("t2");
        check("t2_nostart", 64'(st_idx.size()), 64'(n));

        // T3: all four blocks done in the same cycle
        hold_en = 1;
        begin_job(0, 9);
        ok = 0;
        for (int w = 0; w < 500 && !ok; w++) begin
            @(negedge clk);
            #1;
            ok = 1;
            for (int i = 0; i < N; i++) if (!bact[i] || tmr[i] != 0) ok = 0;
        end
        check("t3_held", 64'(ok), 1);
        mark = rs_idx.size();
        @(posedge clk);
        #1 hold_en = 0;
        wait_done("t3");
        for (int k = 0; k < 3; k++) begin
            check("t3_rr_idx", 64'(rs_idx[mark+k+1]), 64'((rs_idx[mark+k] + 1) % N));
            check("t3_rr_cyc", 64'(rs_cyc[mark+k+1] - rs_cyc[mark+k]), 1);
        end

        // T4: top of region space
        begin_job(16'hFFFE, 16'hFFFF);
        wait_done("t4");

        // T5: abort with three blocks active, then a job with stray done on free blocks
        n = st_idx.size();
        begin_job(0, 7);
        for (int w = 0; w < 50 && st_idx.size() < n + 3; w++) begin
            @(negedge clk);
            #1;
        end
        check("t5_three_started", 64'(st_idx.size() >= n + 3), 1);
        bus.abort = 1;
        @(negedge clk);
        bus.abort = 0;
        check("t5_restart_all", 64'(bus.blk_restart), 64'hF);
        check("t5_busy", 64'(bus.busy), 0);
        check("t5_total_hold", bus.total_count, 0);
        check("t5_rdone_hold", 64'(bus.regions_done), 0);
        @(negedge clk);
        check("t5_restart_pulse", 64'(bus.blk_restart), 0);
        exp_region.delete();
        exp_tot.delete();
        exp_cnt.delete();
        stray_en = 1;
        begin_job(0, 2);
        wait_done("t5_stray");
        stray_en = 0;

        // T6: start while busy is ignored
        begin_job(0, 5);
        repeat (3) @(negedge clk);
        bus.region_first = 16'd100;
        bus.region_last  = 16'd200;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        wait_done("t6");

        // T7: asynchronous reset mid-job
        begin_job(0, 9);
        for (int w = 0; w < 500 && bus.regions_done < 2; w++) @(negedge clk);
        check("t7_progress", 64'(bus.regions_done >= 2), 1);
        #2 rst = 1;
        #1;
        check("t7_busy", 64'(bus.busy), 0);
        check("t7_total", bus.total_count, 0);
        check("t7_rdone", 64'(bus.regions_done), 0);
        check("t7_region", bus.blk_region, 0);
        check("t7_start", 64'(bus.blk_start), 0);
        exp_region.delete();
        exp_tot.delete();
        exp_cnt.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        begin_job(3, 4);
        wait_done("t8");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end
endmodule
